ifid_pipeline_stage: RTL and testbench
======================================

Name: ifid_pipeline_stage

Overview:
- Next-generation IF/ID pipeline register for the 5-stage MIPS core.
- Carries the fetched instruction and its PC from Inst. Fetch to Inst. Decode.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush for branch/jump squash, and a registered PC+4.
- Width parametrised, so the same block can serve wider fetch words or PCs.

Parameters:
- INST_W, 32, instruction word width in bits.
- PC_W, 32, program-counter width in bits.
- NOP_INST, 32'h0000_0000, bubble encoding (sll $0,$0,0) driven on out_inst when no valid entry is present.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  squash all held entries (branch taken / jump redirect).
- in_valid  input  1  IF presents a valid instruction.
- in_ready  output  1  stage can accept; depends only on flops.
- in_inst  input  INST_W  fetched instruction.
- in_pc  input  PC_W  PC of in_inst.
- out_valid  output  1  ID-side entry valid.
- out_ready  input  1  ID consumes the entry (deasserted on hazard stall).
- out_inst  output  INST_W  instruction to ID.
- out_pc  output  PC_W  PC of out_inst.
- out_pc4  output  PC_W  out_pc + 4, registered.

Behaviour:
- Clock and reset: single clock domain `clock`. `reset` is synchronous and active-high; all state updates only on posedge `clock`.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) plus skid register. Occupancy state is EMPTY, FULL or SKID.
- in_ready = (state != SKID), decoded directly from the state flop. There is no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Transitions (no flush):
  - EMPTY: in_valid → main<=in, FULL. Otherwise stay EMPTY.
  - FULL: in_fire & out_fire → main<=in, stay FULL (1 instr/cycle sustained). in_fire only → skid<=in, SKID. out_fire only → EMPTY. Neither → hold.
  - SKID: in_ready=0. out_fire → main<=skid, FULL. Otherwise hold.
- Latency: an instruction accepted in cycle N is visible on out_* in cycle N+1.
- Ordering: strictly FIFO, with no loss or duplication.
- Output stability: while out_valid & !out_ready, out_inst, out_pc and out_pc4 hold unchanged.
- PC arithmetic: out_pc4 is registered alongside out_pc as in_pc + 4, computed modulo 2^PC_W. For PC_W=32, 32'hFFFF_FFFC gives 32'h0000_0000. There is no carry output.
- Bubbles: when out_valid=0, out_inst=NOP_INST and out_pc/out_pc4 hold their last values. ID must qualify these with out_valid.
- Flush (synchronous):
  - Next state is EMPTY; both entries are discarded and out_inst<=NOP_INST.
  - flush has priority over a simultaneous in_valid: that input counts as not accepted (in_ready is still 1 if the state was not SKID, but the data is dropped). IF must re-present after redirect.
  - out_fire in the same cycle as flush is allowed; the consumed entry was already on out_*.
- Reset: state=EMPTY, out_valid=0, in_ready=1, out_inst=NOP_INST, out_pc=0, out_pc4=4, skid contents cleared to 0.
  - Reset mid-operation discards all entries, regardless of flush or handshakes.
  - reset has priority over flush.
- Illegal condition: none. in_valid while in_ready=0 is simply not accepted; IF must hold its data.

Decomposition:
- Shared package `mips_pipe_pkg`:
  - state enum {EMPTY, FULL, SKID} (2-bit).
  - MIPS_NOP constant 32'h0000_0000.
  - PC_INC constant 4.
  - Default INST_W/PC_W values.
- Sub-module: none needed. Main and skid registers with a 3-state controller fit in one module (~150–200 lines). The other pipeline registers (IDEX, EXMEM, MEMWB) will reuse the package and this handshake scheme.

Test Plan:
- Reset, then release: out_valid=0, in_ready=1, out_inst=32'h0, out_pc4=32'h4. Drive in_valid with inst 32'h2008_0005 @ pc 32'h0040_0000 → next cycle out_valid=1, out_inst=32'h2008_0005, out_pc4=32'h0040_0004.
- Streaming: out_ready=1, 8 back-to-back instructions at pc 0x00,0x04,…,0x1C → each appears exactly one cycle after acceptance, in order; in_ready stays 1 throughout.
- Stall/skid: FULL holding pc 0x10; out_ready=0 and pc 0x14 presented → state SKID, in_ready=0, out_pc held at 0x10. Then out_ready=1 → out_pc=0x14 next cycle, in_ready=1 again, no instruction lost.
- Flush in SKID state with in_valid=1 (pc 0x18) → next cycle out_valid=0, out_inst=NOP_INST, in_ready=1. Neither pc 0x14 nor pc 0x18 ever appears on the output.
- PC wrap: in_pc=32'hFFFF_FFFC → out_pc4=32'h0000_0000. Also, reset asserted together with flush while in SKID → EMPTY with reset values.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline registers.
// Reused by IF/ID, ID/EX, EX/MEM and MEM/WB stages.
package mips_pipe_pkg;

  localparam int INST_W_DEF = 32;
  localparam int PC_W_DEF   = 32;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
  localparam int unsigned PC_INC   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/ifid_pipeline_stage.sv
// IF/ID pipeline register with valid/ready handshake,
// 2-entry skid buffer, synchronous flush and registered PC+4.
module ifid_pipeline_stage
  import mips_pipe_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(MIPS_NOP)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc4
);

  occ_state_t        r_state;
  logic [INST_W-1:0] r_main_inst;
  logic [PC_W-1:0]   r_main_pc;
  logic [PC_W-1:0]   r_main_pc4;
  logic [INST_W-1:0] r_skid_inst;
  logic [PC_W-1:0]   r_skid_pc;
  logic [PC_W-1:0]   r_skid_pc4;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [PC_W-1:0]   w_in_pc4;

  assign in_ready   = (r_state != ST_SKID);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_in_pc4   = in_pc + PC_W'(PC_INC);

  // Bubble shows NOP; PCs keep their last loaded values.
  assign out_inst = out_valid ? r_main_inst : NOP_INST;
  assign out_pc   = r_main_pc;
  assign out_pc4  = r_main_pc4;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main_inst <= NOP_INST;
      r_main_pc   <= '0;
      r_main_pc4  <= PC_W'(PC_INC);
      r_skid_inst <= '0;
      r_skid_pc   <= '0;
      r_skid_pc4  <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_main_inst <= NOP_INST;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (in_valid) begin
            r_main_inst <= in_inst;
            r_main_pc   <= in_pc;
            r_main_pc4  <= w_in_pc4;
            r_state     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            r_main_inst <= in_inst;
            r_main_pc   <= in_pc;
            r_main_pc4  <= w_in_pc4;
          end else if (w_in_fire) begin
            r_skid_inst <= in_inst;
            r_skid_pc   <= in_pc;
            r_skid_pc4  <= w_in_pc4;
            r_state     <= ST_SKID;
          end else if (w_out_fire) begin
            r_state     <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_out_fire) begin
            r_main_inst <= r_skid_inst;
            r_main_pc   <= r_skid_pc;
            r_main_pc4  <= r_skid_pc4;
            r_state     <= ST_FULL;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_pipeline_stage.sv
// Randomized bench for ifid_pipeline_stage against a
// queue-based FIFO reference model.
module tb_ifid_pipeline_stage;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_pc4;

  ifid_pipeline_stage dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // FIFO of depth 2; last head PC persists through bubbles.
  task automatic model_step();
    bit acc;
    if (reset) begin
      q.delete();
      m_pc  = 32'h0;
      m_pc4 = 32'h4;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{inst: in_inst, pc: in_pc});
    end
    if (q.size() > 0) begin
      m_pc  = q[0].pc;
      m_pc4 = q[0].pc + 32'd4;
    end
  endtask

  task automatic check_all();
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    chk("out_inst", out_inst, (q.size() > 0) ? q[0].inst : 32'h0);
    chk("out_pc", out_pc, m_pc);
    chk("out_pc4", out_pc4, m_pc4);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] pc,
                       input bit rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = {8'h20, pc[23:0]} ^ 32'h0008_0005;
    out_ready = rdy;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_pc    = 32'h0;
    m_pc4   = 32'h4;
    reset   = 1'b1;
    flush   = 1'b0;
    drive(0, 32'h0, 0);
    @(negedge clock);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_pc4", out_pc4, 32'h4);
    chk("rst_inst", out_inst, 32'h0);

    // First instruction, one-cycle latency
    in_valid  = 1'b1;
    in_inst   = 32'h2008_0005;
    in_pc     = 32'h0040_0000;
    out_ready = 1'b0;
    cycle();
    chk("first_inst", out_inst, 32'h2008_0005);
    chk("first_pc4", out_pc4, 32'h0040_0004);
    drive(0, 32'h0, 1);
    cycle();

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'(i * 4), 1);
      cycle();
      chk("stream_pc", out_pc, 32'(i * 4));
    end
    drive(0, 32'h0, 1);
    cycle();

    // Stall into skid, then drain
    drive(1, 32'h10, 1);
    cycle();
    drive(1, 32'h14, 0);
    cycle();
    chk("skid_rdy", {31'b0, in_ready}, 32'h0);
    chk("skid_hold", out_pc, 32'h10);
    drive(0, 32'h0, 1);
    cycle();
    chk("drain_pc", out_pc, 32'h14);
    chk("drain_rdy", {31'b0, in_ready}, 32'h1);

    // Refill to skid and flush with in_valid high
    drive(1, 32'h20, 0);
    cycle();
    drive(1, 32'h24, 0);
    cycle();
    drive(1, 32'h28, 0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_inst", out_inst, 32'h0);
    drive(0, 32'h0, 1);
    cycle();

    // PC wrap
    drive(1, 32'hFFFF_FFFC, 0);
    cycle();
    chk("wrap_pc4", out_pc4, 32'h0);

    // Reset together with flush while in skid
    drive(1, 32'h30, 0);
    cycle();
    reset = 1'b1;
    flush = 1'b1;
    drive(1, 32'h34, 0);
    cycle();
    reset = 1'b0;
    flush = 1'b0;
    drive(0, 32'h0, 0);
    chk("rf_pc", out_pc, 32'h0);
    chk("rf_pc4", out_pc4, 32'h4);
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      in_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                               : ($urandom() & 32'hFFFF_FFFC);
      in_inst   = $urandom();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
